unrank32: RTL and testbench



---
 rtl/unrank32_pkg.sv | 41 ++++
 rtl/unrank32_if.sv | 12 +
 rtl/unrank32_binom_rom.sv | 21 ++
 rtl/unrank32.sv | 52 +++++
 tb/tb_unrank32.sv | 140 ++++++++++++++
 5 files changed

// File: rtl/unrank32_pkg.sv
// Shared types and elaboration-time binomial helpers for combinadic unranking.
// Holds widths, the saturated binomial type and Pascal-triangle constant functions.
package unrank_pkg;

  localparam int NUM_W = 32;
  localparam int IDX_W = 6;
  localparam int NROW  = 1 << IDX_W;
  localparam int BIN_W = NUM_W + 1;

  typedef logic [BIN_W-1:0] binom_t;

  // Saturation value 2^32: anything at or above it never fits a 32-bit rank.
  localparam binom_t BSAT = {1'b1, {NUM_W{1'b0}}};

  function automatic binom_t sat_add(binom_t a, binom_t b);
    logic [BIN_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s > {1'b0, BSAT}) ? BSAT : s[BIN_W-1:0];
  endfunction

  // Row r of Pascal's triangle, C(r,0..63), built in place.
  function automatic binom_t [NROW-1:0] binom_row(int r);
    binom_t [NROW-1:0] c;
    c    = '0;
    c[0] = binom_t'(1);
    for (int n = 1; n <= r; n++) begin
      for (int j = n; j >= 1; j--) begin
        c[IDX_W'(j)] = sat_add(c[IDX_W'(j)], c[IDX_W'(j-1)]);
      end
    end
    return c;
  endfunction

  function automatic binom_t binom_sat(int r, int k);
    binom_t [NROW-1:0] v;
    if (r < 0 || r >= NROW || k < 0 || k >= NROW) return '0;
    v = binom_row(r);
    return v[IDX_W'(k)];
  endfunction

endpackage

// File: rtl/unrank32_if.sv
// Lookup bus for unrank32: rank and order in, row out.
// master drives num/col and reads row; slave is the lookup block.
interface unrank32_if;
  import unrank_pkg::*;

  logic [NUM_W-1:0] num;
  logic [IDX_W-1:0] col;
  logic [IDX_W-1:0] row;

  modport master (output num, output col, input row);
  modport slave  (input num, input col, output row);
endinterface

// File: rtl/unrank32_binom_rom.sv
// Constant table of saturated binomials C(0..63, col), selected by col.
// Ports: col (order k) in, thr (64 x 33-bit thresholds) out.
module unrank32_binom_rom
  import unrank_pkg::*;
(
  input  logic [IDX_W-1:0]  col,
  output binom_t [NROW-1:0] thr
);

  binom_t [NROW-1:0] tbl [NROW];

  for (genvar gr = 0; gr < NROW; gr++) begin : g_r
    localparam binom_t [NROW-1:0] PROW = binom_row(gr);
    for (genvar gk = 0; gk < NROW; gk++) begin : g_k
      assign tbl[gk][gr] = PROW[gk];
    end
  end

  assign thr = tbl[col];

endmodule

// File: rtl/unrank32.sv
// Combinadic unrank step: row = largest r in 0..63 with C(r,col) <= num.
// Ports: clk, rst_n (async, active-low), bus (slave: num, col in; row out, 2-cycle latency).
module unrank32
  import unrank_pkg::*;
(
  input logic       clk,
  input logic       rst_n,
  unrank32_if.slave bus
);

  logic [NUM_W-1:0]  num_q;
  logic [IDX_W-1:0]  col_q;
  binom_t [NROW-1:0] thr;
  logic [NROW-1:0]   hit;
  logic [IDX_W:0]    total;
  logic [IDX_W-1:0]  row_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      num_q <= '0;
      col_q <= '0;
    end else begin
      num_q <= bus.num;
      col_q <= bus.col;
    end
  end

  unrank32_binom_rom u_rom (
    .col (col_q),
    .thr (thr)
  );

  for (genvar g = 0; g < NROW; g++) begin : g_cmp
    assign hit[g] = thr[g] <= {1'b0, num_q};
  end

  // Rows below col have C = 0 and always hit, so the hit count is
  // col + (qualifying rows at or above col); the largest row is count-1.
  // A zero count only happens for col = 0 with num = 0.
  assign total = (IDX_W+1)'($countones(hit));

  always_comb begin
    row_d = '0;
    if (total != '0) row_d = IDX_W'(total - 1'b1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bus.row <= '0;
    else        bus.row <= row_d;
  end

endmodule

// File: tb/tb_unrank32.sv
// Self-checking bench for unrank32 against a multiplicative-formula model.
// Covers reset, col=3 sweep, corners, saturation and per-cycle random streaming.
module tb_unrank32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  unrank32_if bus ();

  unrank32 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  localparam longint SATV = 64'h1_0000_0000;

  function automatic longint cbin(int r, int k);
    longint c;
    if (k > r) return 0;
    c = 1;
    for (int i = 1; i <= k; i++) begin
      c = c * (r - k + i) / i;
      if (c > SATV) return SATV;
    end
    return c;
  endfunction

  function automatic logic [5:0] ref_row(logic [31:0] num, logic [5:0] col);
    for (int r = 63; r >= 0; r--)
      if (cbin(r, int'(col)) <= longint'(num)) return 6'(r);
    return 6'd0;
  endfunction

  task automatic chk(string tag, logic [5:0] obs, logic [5:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: row=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic look(logic [31:0] n, logic [5:0] c, logic [5:0] exp, string tag);
    bus.num = n;
    bus.col = c;
    repeat (2) @(posedge clk);
    #1;
    chk(tag, bus.row, exp);
  endtask

  logic [31:0] qn [$];
  logic [5:0]  qc [$];
  logic [31:0] rn;
  logic [5:0]  rc;

  initial begin
    bus.num = $urandom;
    bus.col = 6'($urandom_range(0, 63));
    repeat (3) @(posedge clk);
    #1;
    chk("reset_hold", bus.row, 6'd0);
    bus.num = $urandom;
    @(posedge clk);
    #1;
    chk("reset_hold2", bus.row, 6'd0);

    rst_n = 1'b1;
    bus.num = 32'd9;
    bus.col = 6'd3;
    @(posedge clk);
    #1;
    chk("release_lat1", bus.row, 6'd0);
    @(posedge clk);
    #1;
    chk("release_lat2", bus.row, 6'd4);

    for (int n = 0; n <= 20; n++) begin
      automatic logic [5:0] e;
      e = (n == 0) ? 6'd2 : (n < 4) ? 6'd3 : (n < 10) ? 6'd4 :
          (n < 20) ? 6'd5 : 6'd6;
      look(32'(n), 6'd3, e, $sformatf("col3_num%0d", n));
    end

    look(32'd0, 6'd0, 6'd0, "col0_num0");
    look(32'd1, 6'd0, 6'd63, "col0_num1");
    look(32'hFFFF_FFFF, 6'd0, 6'd63, "col0_max");
    look(32'd0, 6'd63, 6'd62, "col63_num0");
    look(32'd1, 6'd63, 6'd63, "col63_num1");
    look(32'd62, 6'd1, 6'd62, "col1_num62");
    look(32'd63, 6'd1, 6'd63, "col1_num63");
    look(32'hFFFF_FFFF, 6'd1, 6'd63, "col1_max");
    look(32'hFFFF_FFFF, 6'd32, 6'd42, "col32_max_const");
    look(32'hFFFF_FFFF, 6'd32, ref_row(32'hFFFF_FFFF, 6'd32),
         "col32_max_model");
    look(32'hFFFF_FFFF, 6'd2, ref_row(32'hFFFF_FFFF, 6'd2), "col2_max");

    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      #1;
      if (qn.size() == 2) begin
        rn = qn.pop_front();
        rc = qc.pop_front();
        chk($sformatf("stream%0d", i), bus.row, ref_row(rn, rc));
      end
      case (i % 4)
        0: rn = $urandom;
        1: rn = $urandom_range(0, 1000);
        2: rn = 32'($urandom) >> $urandom_range(0, 31);
        default: rn = $urandom_range(0, 3);
      endcase
      rc = 6'($urandom_range(0, 63));
      if (i % 3 == 0) rc = 6'($urandom_range(0, 8));
      bus.num = rn;
      bus.col = rc;
      qn.push_back(rn);
      qc.push_back(rc);
    end

    bus.num = 32'd500;
    bus.col = 6'd2;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_reset", bus.row, 6'd0);
    @(posedge clk);
    #1;
    chk("async_reset_hold", bus.row, 6'd0);
    rst_n = 1'b1;
    look(32'd500, 6'd2, ref_row(32'd500, 6'd2), "post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
